alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Multi-cycle issue controller that drives the 8-bit ALU from the initiator side. It accepts 32-bit instruction words over a valid/ready handshake and decodes them. It reads operands from an internal 8×8 register file, presents operands and select to the ALU, and captures the ALU result. It then writes that result back. It is the control/datapath front end that sits between the instruction source and the ALU in the processor.

## Interface
- REG_ADDR_W, 3, register address width; register file depth = 2**REG_ADDR_W
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- instr_valid  in  1  instruction word present
- instr_ready  out  1  controller can accept; high only in IDLE
- instr  in  32  [31:24] opcode, [23:16] dest, [15:8] src1, [7:0] src2/immediate; register fields use low REG_ADDR_W bits
- alu_a  out  8  ALU operand A (registered)
- alu_b  out  8  ALU operand B (registered)
- alu_sel  out  3  ALU select (registered): 0 forward, 1 add, 2 and, 3 or, 7 idle
- alu_result  in  8  ALU combinational result
- wb_addr  out  REG_ADDR_W  write-back register address
- wb_data  out  8  write-back data
- done  out  1  one-cycle pulse, instruction retired
- illegal  out  1  one-cycle pulse, opcode rejected
- rd_addr  in  REG_ADDR_W  debug read address
- rd_data  out  8  combinational read of reg[rd_addr]

## Operation
- FSM states: IDLE, DECODE, EXECUTE, WRITEBACK.
- IDLE: instr_ready=1, alu_sel=7. On instr_valid&&instr_ready, latch instr and go to DECODE.
- DECODE: decode opcode and read operands.
  - 0x00 LOADI: alu_a=imm, alu_b=0, sel=0.
  - 0x01 MOV: alu_a=reg[src2], alu_b=0, sel=0.
  - 0x02 ADD: sel=1, alu_a=reg[src1], alu_b=reg[src2].
  - 0x03 AND: sel=2, same operands as ADD.
  - 0x04 OR: sel=3, same operands as ADD.
  - Legal opcode: register alu_a/alu_b/alu_sel, then go to EXECUTE.
  - Any other opcode: go to IDLE. No ALU output change, no write, illegal pulse.
- EXECUTE: hold alu_a/alu_b/alu_sel stable. At end of cycle capture alu_result into result_q, then go to WRITEBACK.
- WRITEBACK: wb_addr=dest, wb_data=result_q, done=1. reg[dest] written at end of cycle. Return to IDLE.
- alu_sel returns to 7 in IDLE, so every issued op produces a select transition. alu_a/alu_b hold their last values in IDLE.
- Arithmetic is 8-bit, carry dropped (mod 256).
- Operands are read in DECODE, so dest may equal src1/src2. The old value is used.
- All registers, including r0, are writable. There is no hardwired zero.
- instr_valid while instr_ready=0 is ignored. The instr word is not sampled.
- rd_data reflects a write-back from the cycle after the write edge.

## Timing
- E0 = accept edge.
- Legal instruction:
  - DECODE during E0–E1; ALU inputs valid after E1.
  - EXECUTE during E1–E2; result_q captured at E2.
  - WRITEBACK during E2–E3; done=1; register written at E3.
  - instr_ready=1 again after E3. Earliest next accept is E4. Throughput is 1 instruction per 4 cycles.
- Illegal instruction: illegal=1 during E1–E2, instr_ready=1 during E1–E2, next accept possible at E2.
- done and illegal are never high together. Each is high for exactly one cycle per instruction.
- Reset values: state IDLE, instr_ready=1, alu_a=0, alu_b=0, alu_sel=7, wb_addr=0, wb_data=0, done=0, illegal=0, all registers 0.
- Reset asserted mid-instruction: immediate return to reset values. The in-flight instruction is dropped with no done and no write-back. Accept resumes on the first edge after deassertion.

## Test plan
- Reset, then idle 5 cycles -> instr_ready=1, alu_sel=7, done=0, illegal=0, rd_data=0 for all addresses.
- LOADI r1,0x07; LOADI r2,0x03; ADD r3,r1,r2 -> alu_sel=1 in EXECUTE with alu_a=7, alu_b=3; done one cycle at WRITEBACK; rd r3=0x0A; accepts spaced exactly 4 cycles when instr_valid held high.
- Continuing: AND r4,r1,r2 -> r4=0x03; OR r5,r1,r2 -> r5=0x07; MOV r6,r1 -> r6=0x07; ADD r1,r1,r1 -> r1=0x0E (dest equals source).
- LOADI r0,0xF0; LOADI r7,0x20; ADD r0,r0,r7 -> r0=0x10 (wrap, no carry out).
- Opcode 0x09 -> illegal=1 in cycle after E1, done never asserted, all registers unchanged, alu_sel stays 7, next instruction accepted at E2.
- Reset pulsed during EXECUTE of ADD r3 -> no done, r3=0, all outputs at reset values. After deassertion, LOADI r3,0x55 -> r3=0x55.

Source files
------------

// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: bundles the signals between the issue controller and its surroundings.
//   instr_valid/instr_ready/instr : instruction handshake from the instruction source
//   alu_a/alu_b/alu_sel/alu_result : operand/select bus to the 8-bit ALU and its result
//   wb_addr/wb_data/done/illegal   : write-back and retire/reject status
//   rd_addr/rd_data                : debug read port into the register file
// Modports: master = environment (source, ALU, debug), slave = the controller.
interface alu_issue_ctrl_if #(
   parameter int unsigned REG_ADDR_W = 3
) ();
   logic                  instr_valid;
   logic                  instr_ready;
   logic [31:0]           instr;
   logic [7:0]            alu_a;
   logic [7:0]            alu_b;
   logic [2:0]            alu_sel;
   logic [7:0]            alu_result;
   logic [REG_ADDR_W-1:0] wb_addr;
   logic [7:0]            wb_data;
   logic                  done;
   logic                  illegal;
   logic [REG_ADDR_W-1:0] rd_addr;
   logic [7:0]            rd_data;

   modport master (
      output instr_valid, instr, alu_result, rd_addr,
      input  instr_ready, alu_a, alu_b, alu_sel, wb_addr, wb_data, done, illegal, rd_data
   );

   modport slave (
      input  instr_valid, instr, alu_result, rd_addr,
      output instr_ready, alu_a, alu_b, alu_sel, wb_addr, wb_data, done, illegal, rd_data
   );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: four-state issue controller in front of an 8-bit ALU.
// Accepts an instruction in idle, reads operands from an internal register file in decode,
// holds the ALU inputs for one execute cycle, captures the ALU result, then writes it back.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : alu_issue_ctrl_if.slave (handshake, ALU bus, write-back, status, debug read)
module alu_issue_ctrl #(
   parameter int unsigned REG_ADDR_W = 3
) (
   input logic              clk,
   input logic              reset,
   alu_issue_ctrl_if.slave  bus
);
   localparam int unsigned Depth = 2 ** REG_ADDR_W;
   localparam logic [2:0] SelFwd  = 3'd0;
   localparam logic [2:0] SelAdd  = 3'd1;
   localparam logic [2:0] SelAnd  = 3'd2;
   localparam logic [2:0] SelOr   = 3'd3;
   localparam logic [2:0] SelIdle = 3'd7;

   typedef enum logic [1:0] {
      s_idle, s_decode, s_execute, s_writeback
   } state_t;

   state_t                state_q, state_d;
   logic [7:0]            op_q, op_d;
   logic [REG_ADDR_W-1:0] dest_q, dest_d;
   logic [REG_ADDR_W-1:0] src1_q, src1_d;
   logic [7:0]            imm_q, imm_d;
   logic [7:0]            alu_a_q, alu_a_d;
   logic [7:0]            alu_b_q, alu_b_d;
   logic [2:0]            alu_sel_q, alu_sel_d;
   logic [7:0]            result_q, result_d;
   logic                  illegal_q, illegal_d;
   logic                  wr_en;
   logic [7:0]            regs_q [Depth];
   logic [7:0]            src1_val, src2_val;

   // Operands come from the pre-write-back register contents, so dest may alias a source.
   assign src1_val = regs_q[src1_q];
   assign src2_val = regs_q[imm_q[REG_ADDR_W-1:0]];

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      dest_d    = dest_q;
      src1_d    = src1_q;
      imm_d     = imm_q;
      alu_a_d   = alu_a_q;
      alu_b_d   = alu_b_q;
      alu_sel_d = alu_sel_q;
      result_d  = result_q;
      illegal_d = 1'b0;
      wr_en     = 1'b0;
      unique case (state_q)
         s_idle: begin
            if (bus.instr_valid) begin
               op_d    = bus.instr[31:24];
               dest_d  = bus.instr[16 +: REG_ADDR_W];
               src1_d  = bus.instr[8 +: REG_ADDR_W];
               imm_d   = bus.instr[7:0];
               state_d = s_decode;
            end
         end
         s_decode: begin
            state_d = s_execute;
            case (op_q)
               8'h00: begin alu_a_d = imm_q;    alu_b_d = '0;       alu_sel_d = SelFwd; end
               8'h01: begin alu_a_d = src2_val; alu_b_d = '0;       alu_sel_d = SelFwd; end
               8'h02: begin alu_a_d = src1_val; alu_b_d = src2_val; alu_sel_d = SelAdd; end
               8'h03: begin alu_a_d = src1_val; alu_b_d = src2_val; alu_sel_d = SelAnd; end
               8'h04: begin alu_a_d = src1_val; alu_b_d = src2_val; alu_sel_d = SelOr;  end
               default: begin
                  // Rejected: ALU bus untouched, back to idle with a one-cycle pulse.
                  state_d   = s_idle;
                  illegal_d = 1'b1;
               end
            endcase
         end
         s_execute: begin
            result_d = bus.alu_result;
            state_d  = s_writeback;
         end
         s_writeback: begin
            wr_en     = 1'b1;
            alu_sel_d = SelIdle;
            state_d   = s_idle;
         end
         default: state_d = s_idle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= s_idle;
         op_q      <= '0;
         dest_q    <= '0;
         src1_q    <= '0;
         imm_q     <= '0;
         alu_a_q   <= '0;
         alu_b_q   <= '0;
         alu_sel_q <= SelIdle;
         result_q  <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         dest_q    <= dest_d;
         src1_q    <= src1_d;
         imm_q     <= imm_d;
         alu_a_q   <= alu_a_d;
         alu_b_q   <= alu_b_d;
         alu_sel_q <= alu_sel_d;
         result_q  <= result_d;
         illegal_q <= illegal_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < Depth; i++) regs_q[i] <= '0;
      end else if (wr_en) begin
         regs_q[dest_q] <= result_q;
      end
   end

   assign bus.instr_ready = (state_q == s_idle);
   assign bus.alu_a       = alu_a_q;
   assign bus.alu_b       = alu_b_q;
   assign bus.alu_sel     = alu_sel_q;
   assign bus.wb_addr     = dest_q;
   assign bus.wb_data     = result_q;
   assign bus.done        = (state_q == s_writeback);
   assign bus.illegal     = illegal_q;
   assign bus.rd_data     = regs_q[bus.rd_addr];
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed bench for alu_issue_ctrl with a cycle-level reference model
// (instruction phase counter plus a plain register array) checked every falling edge,
// plus literal expectations for the documented scenarios.
module tb_alu_issue_ctrl;
   logic clk;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   alu_issue_ctrl_if #(.REG_ADDR_W(3)) bus ();
   alu_issue_ctrl #(.REG_ADDR_W(3)) dut (.clk(clk), .reset(reset), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Simple ALU on the far side of the bus.
   always_comb begin
      case (bus.alu_sel)
         3'd0:    bus.alu_result = bus.alu_a;
         3'd1:    bus.alu_result = bus.alu_a + bus.alu_b;
         3'd2:    bus.alu_result = bus.alu_a & bus.alu_b;
         3'd3:    bus.alu_result = bus.alu_a | bus.alu_b;
         default: bus.alu_result = 8'h00;
      endcase
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int         ph;        // 0 idle, 1 decode, 2 execute, 3 writeback
   logic [31:0] mi;
   logic [7:0]  mregs [8];
   logic [7:0]  exp_a, exp_b, mres;
   logic [2:0]  exp_sel;
   logic        exp_ill;

   task automatic model_clear();
      ph = 0; mi = '0; exp_a = '0; exp_b = '0; mres = '0; exp_sel = 3'd7; exp_ill = 1'b0;
      for (int i = 0; i < 8; i++) mregs[i] = '0;
   endtask

   task automatic model_step();
      logic [7:0] op, ra, rb;
      op = mi[31:24];
      ra = mregs[mi[10:8]];
      rb = mregs[mi[2:0]];
      exp_ill = 1'b0;
      case (ph)
         0: if (bus.instr_valid) begin mi = bus.instr; ph = 1; end
         1: begin
            ph = 2;
            case (op)
               8'h00: begin exp_a = mi[7:0]; exp_b = 0;  exp_sel = 0; mres = mi[7:0]; end
               8'h01: begin exp_a = rb;      exp_b = 0;  exp_sel = 0; mres = rb;      end
               8'h02: begin exp_a = ra;      exp_b = rb; exp_sel = 1; mres = ra + rb; end
               8'h03: begin exp_a = ra;      exp_b = rb; exp_sel = 2; mres = ra & rb; end
               8'h04: begin exp_a = ra;      exp_b = rb; exp_sel = 3; mres = ra | rb; end
               default: begin ph = 0; exp_ill = 1'b1; end
            endcase
         end
         2: ph = 3;
         default: begin mregs[mi[18:16]] = mres; exp_sel = 3'd7; ph = 0; end
      endcase
   endtask

   initial begin
      model_clear();
      forever begin
         @(posedge clk or posedge reset);
         if (reset) model_clear();
         else model_step();
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      forever begin
         @(negedge clk);
         chk("instr_ready", 32'(bus.instr_ready), 32'(ph == 0));
         chk("done", 32'(bus.done), 32'(ph == 3));
         chk("illegal", 32'(bus.illegal), 32'(exp_ill));
         chk("alu_sel", 32'(bus.alu_sel), 32'(exp_sel));
         chk("alu_a", 32'(bus.alu_a), 32'(exp_a));
         chk("alu_b", 32'(bus.alu_b), 32'(exp_b));
         chk("rd_data", 32'(bus.rd_data), 32'(mregs[bus.rd_addr]));
         if (ph == 3) begin
            chk("wb_addr", 32'(bus.wb_addr), 32'(mi[18:16]));
            chk("wb_data", 32'(bus.wb_data), 32'(mres));
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   function automatic logic [31:0] mk(input logic [7:0] op, input logic [7:0] d,
                                      input logic [7:0] s1, input logic [7:0] s2);
      return {op, d, s1, s2};
   endfunction

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #2; end
   endtask

   // Present w until accepted; returns the accept edge time.
   task automatic send(input logic [31:0] w, input bit drop, output time t);
      bit ok;
      ok = 1'b0;
      bus.instr = w;
      bus.instr_valid = 1'b1;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (bus.instr_ready) ok = 1'b1;
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: instr %08h not accepted within 20 cycles", w);
         bus.instr_valid = 1'b0;
         t = $time;
      end else begin
         @(posedge clk);
         t = $time;
         #2;
         if (drop) bus.instr_valid = 1'b0;
      end
   endtask

   task automatic peek(input string name, input logic [2:0] a, input logic [7:0] exp);
      bus.rd_addr = a;
      #1;
      chk(name, 32'(bus.rd_data), 32'(exp));
   endtask

   task automatic chk_reset_vals();
      chk("rst_ready", 32'(bus.instr_ready), 32'd1);
      chk("rst_sel", 32'(bus.alu_sel), 32'd7);
      chk("rst_a", 32'(bus.alu_a), 32'd0);
      chk("rst_b", 32'(bus.alu_b), 32'd0);
      chk("rst_wb_addr", 32'(bus.wb_addr), 32'd0);
      chk("rst_wb_data", 32'(bus.wb_data), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_illegal", 32'(bus.illegal), 32'd0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      time t0, t1, t2;
      bus.instr_valid = 1'b0;
      bus.instr = '0;
      bus.rd_addr = '0;
      reset = 1'b0;
      #1 reset = 1'b1;
      #1 chk_reset_vals();
      @(posedge clk); @(posedge clk); #2;
      reset = 1'b0;

      // Idle: every register reads zero.
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #2;
         peek("idle_rd", 3'(i), 8'h00);
      end
      peek("idle_rd7", 3'd7, 8'h00);
      chk("idle_sel", 32'(bus.alu_sel), 32'd7);

      // Back-to-back with valid held: accepts exactly 4 cycles apart.
      send(mk(8'h00, 8'd1, 8'd0, 8'h07), 1'b0, t0);
      send(mk(8'h00, 8'd2, 8'd0, 8'h03), 1'b0, t1);
      send(mk(8'h02, 8'd3, 8'd1, 8'd2), 1'b1, t2);
      chk("gap_1", 32'(t1 - t0), 32'd40);
      chk("gap_2", 32'(t2 - t1), 32'd40);
      idle(1);
      chk("exec_sel", 32'(bus.alu_sel), 32'd1);
      chk("exec_a", 32'(bus.alu_a), 32'h07);
      chk("exec_b", 32'(bus.alu_b), 32'h03);
      idle(3);
      peek("add_r3", 3'd3, 8'h0A);

      send(mk(8'h03, 8'd4, 8'd1, 8'd2), 1'b1, t0); idle(4);
      send(mk(8'h04, 8'd5, 8'd1, 8'd2), 1'b1, t0); idle(4);
      send(mk(8'h01, 8'd6, 8'd0, 8'd1), 1'b1, t0); idle(4);
      send(mk(8'h02, 8'd1, 8'd1, 8'd1), 1'b1, t0); idle(4);
      peek("and_r4", 3'd4, 8'h03);
      peek("or_r5", 3'd5, 8'h07);
      peek("mov_r6", 3'd6, 8'h07);
      peek("alias_r1", 3'd1, 8'h0E);

      // Wraparound add into r0.
      send(mk(8'h00, 8'd0, 8'd0, 8'hF0), 1'b1, t0); idle(4);
      send(mk(8'h00, 8'd7, 8'd0, 8'h20), 1'b1, t0); idle(4);
      send(mk(8'h02, 8'd0, 8'd0, 8'd7), 1'b1, t0); idle(4);
      peek("wrap_r0", 3'd0, 8'h10);

      // Illegal opcode: pulse, no write, next accept two cycles later.
      send(mk(8'h09, 8'd2, 8'd1, 8'd2), 1'b0, t0);
      idle(1);
      chk("ill_pulse", 32'(bus.illegal), 32'd1);
      chk("ill_done", 32'(bus.done), 32'd0);
      chk("ill_sel", 32'(bus.alu_sel), 32'd7);
      send(mk(8'h00, 8'd5, 8'd0, 8'h07), 1'b1, t1);
      chk("ill_gap", 32'(t1 - t0), 32'd20);
      idle(4);
      peek("ill_r2", 3'd2, 8'h03);

      // Reset during execute drops the instruction.
      send(mk(8'h02, 8'd3, 8'd1, 8'd2), 1'b1, t0);
      @(posedge clk); #2;
      reset = 1'b1;
      #1 chk_reset_vals();
      @(posedge clk); #2;
      reset = 1'b0;
      peek("rst_r3", 3'd3, 8'h00);
      send(mk(8'h00, 8'd3, 8'd0, 8'h55), 1'b1, t0);
      idle(4);
      peek("post_rst_r3", 3'd3, 8'h55);

      idle(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
